// File: rtl/mag_comparator_seq.sv
// Sequential, cascadable magnitude comparator.
// The operands are walked CHUNK bits per cycle, starting with the most
// significant chunk. Signed mode flips the sign bit of both operands so that
// every chunk can then be compared as a plain unsigned value. When the operands
// are equal, the cascade inputs from the lower-significance stage decide the result.
module mag_comparator_seq #(
    parameter int WIDTH      = 64,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             greatin,
    input  logic             equalin,
    input  logic             lessin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             great,
    output logic             equal,
    output logic             less
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [2:0]        casc_reg;
    logic [IDXW-1:0]   idx_reg;
    logic              found_reg;
    logic              rec_great_reg, rec_less_reg;
    logic              great_reg, equal_reg, less_reg;

    logic [CHUNK-1:0]  a_chunks [NCHUNK];
    logic [CHUNK-1:0]  b_chunks [NCHUNK];
    logic [CHUNK-1:0]  chunk_a, chunk_b;
    logic              diff_now;
    logic              last_chunk;
    logic              finish;
    logic [2:0]        res_next;

    // Slice the captured operands into chunks so the per-cycle compare is a simple mux.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunks
            assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // Compare the current chunk and decide whether this is the final RUN cycle.
    always_comb begin
        chunk_a    = a_chunks[idx_reg];
        chunk_b    = b_chunks[idx_reg];
        last_chunk = (idx_reg == '0);
        diff_now   = (state_reg == RUN) && !found_reg && (chunk_a != chunk_b);
        finish     = (state_reg == RUN) && (last_chunk || (diff_now && (EARLY_EXIT != 0)));
        // The first difference wins; with no difference at all, the cascade decides.
        if (diff_now) begin
            res_next = {chunk_a > chunk_b, 1'b0, chunk_a < chunk_b};
        end else if (found_reg) begin
            res_next = {rec_great_reg, 1'b0, rec_less_reg};
        end else begin
            res_next = casc_reg;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (finish)    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture. Signed operands are stored in offset-binary form.
    always_ff @(posedge clk) begin
        if (state_reg == IDLE && in_valid) begin
            a_reg    <= is_signed ? (a ^ MSB_MASK) : a;
            b_reg    <= is_signed ? (b ^ MSB_MASK) : b;
            casc_reg <= {greatin, equalin, lessin};
        end
    end

    // Chunk walk, first-difference record and the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg       <= '0;
            found_reg     <= 1'b0;
            rec_great_reg <= 1'b0;
            rec_less_reg  <= 1'b0;
            great_reg     <= 1'b0;
            equal_reg     <= 1'b0;
            less_reg      <= 1'b0;
        end else if (state_reg == IDLE) begin
            if (in_valid) begin
                idx_reg   <= IDXW'(NCHUNK - 1);
                found_reg <= 1'b0;
            end
        end else if (state_reg == RUN) begin
            if (diff_now) begin
                found_reg     <= 1'b1;
                rec_great_reg <= chunk_a > chunk_b;
                rec_less_reg  <= chunk_a < chunk_b;
            end
            if (finish) begin
                great_reg <= res_next[2];
                equal_reg <= res_next[1];
                less_reg  <= res_next[0];
            end else begin
                idx_reg <= idx_reg - IDXW'(1);
            end
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign great     = great_reg;
    assign equal     = equal_reg;
    assign less      = less_reg;

endmodule

// File: tb/tb_mag_comparator_seq.sv
// Self-checking bench for mag_comparator_seq. Four instances with different
// CHUNK/EARLY_EXIT settings share one stimulus stream and are checked
// against an arithmetic reference model for both result and latency.
module tb_mag_comparator_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        is_signed = 1'b0;
    logic [2:0]  casc = 3'b010;
    logic [3:0]  in_ready, out_valid, great, equal, less;

    int total = 0;
    int bad = 0;
    int obs_lat [4];
    logic [2:0] obs_res [4];
    logic [3:0] obs_inready;

    always #5 clk = ~clk;

    mag_comparator_seq #(.WIDTH(64), .CHUNK(8), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .is_signed(is_signed),
        .greatin(casc[2]), .equalin(casc[1]), .lessin(casc[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .great(great[0]), .equal(equal[0]), .less(less[0]));

    mag_comparator_seq #(.WIDTH(64), .CHUNK(8), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .is_signed(is_signed),
        .greatin(casc[2]), .equalin(casc[1]), .lessin(casc[0]),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .great(great[1]), .equal(equal[1]), .less(less[1]));

    mag_comparator_seq #(.WIDTH(64), .CHUNK(16), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
        .a(a), .b(b), .is_signed(is_signed),
        .greatin(casc[2]), .equalin(casc[1]), .lessin(casc[0]),
        .out_valid(out_valid[2]), .out_ready(out_ready),
        .great(great[2]), .equal(equal[2]), .less(less[2]));

    mag_comparator_seq #(.WIDTH(64), .CHUNK(64), .EARLY_EXIT(0)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]),
        .a(a), .b(b), .is_signed(is_signed),
        .greatin(casc[2]), .equalin(casc[1]), .lessin(casc[0]),
        .out_valid(out_valid[3]), .out_ready(out_ready),
        .great(great[3]), .equal(equal[3]), .less(less[3]));

    function automatic int ch_of(int i);
        case (i)
            0, 1:    return 8;
            2:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int ee_of(int i);
        return (i == 0 || i == 2) ? 1 : 0;
    endfunction

    // Reference result {great, equal, less}: equal operands pass the cascade through.
    function automatic logic [2:0] model_res(logic [63:0] x, logic [63:0] y, logic s, logic [2:0] c);
        if (x == y) return c;
        if (s) return ($signed(x) > $signed(y)) ? 3'b100 : 3'b001;
        return (x > y) ? 3'b100 : 3'b001;
    endfunction

    // Reference latency k: position (from MSB, 1-based) of the first differing chunk.
    function automatic int model_k(logic [63:0] x, logic [63:0] y, int ch, int ee);
        int n;
        logic [63:0] d;
        n = 64 / ch;
        d = x ^ y;
        if (ee == 0 || d == 0) return n;
        for (int p = 63; p >= 0; p--) begin
            if (d[p]) return n - p / ch;
        end
        return n;
    endfunction

    // Present one operand set, then record per-instance latency and result (no release).
    task automatic run_txn(input logic [63:0] ta, input logic [63:0] tb_v, input logic ts, input logic [2:0] tc);
        int seen;
        a = ta; b = tb_v; is_signed = ts; casc = tc; in_valid = 1'b1;
        obs_inready = in_ready;
        for (int i = 0; i < 4; i++) begin
            obs_lat[i] = 0;
            obs_res[i] = 3'b000;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int n = 1; n <= 20 && seen < 4; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && obs_lat[i] == 0) begin
                    obs_lat[i] = n;
                    obs_res[i] = {great[i], equal[i], less[i]};
                    seen++;
                end
            end
        end
        $display("txn a=%h b=%h s=%0d casc=%b lat=%0d/%0d/%0d/%0d res=%b/%b/%b/%b",
                 ta, tb_v, ts, tc, obs_lat[0], obs_lat[1], obs_lat[2], obs_lat[3],
                 obs_res[0], obs_res[1], obs_res[2], obs_res[3]);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 4'h0 || out_valid !== 4'h0) begin
            bad++;
            $display("FAIL reset_handshake in_ready=%b out_valid=%b required 0000/0000", in_ready, out_valid);
        end
        total++;
        if ({great, equal, less} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs g=%b e=%b l=%b required all 0", great, equal, less);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 4'hF) begin
            bad++;
            $display("FAIL reset_release in_ready=%b required 1111", in_ready);
        end
    endtask

    // Directed cases: LSB-chunk difference, signed vs unsigned MSB difference, cascade.
    task automatic test_directed();
        logic [63:0] ta [8];
        logic [63:0] tbv [8];
        logic        ts [8];
        logic [2:0]  tc [8];
        logic [2:0]  exp_r;
        int          exp_k;
        ta[0] = 64'h00000000_000000FF; tbv[0] = 64'h00000000_000000FE; ts[0] = 0; tc[0] = 3'b010;
        ta[1] = 64'h80000000_00000000; tbv[1] = 64'h1;                 ts[1] = 0; tc[1] = 3'b010;
        ta[2] = 64'h80000000_00000000; tbv[2] = 64'h1;                 ts[2] = 1; tc[2] = 3'b010;
        ta[3] = 64'h12345678_9ABCDEF0; tbv[3] = 64'h12345678_9ABCDEF0; ts[3] = 0; tc[3] = 3'b100;
        ta[4] = 64'h12345678_9ABCDEF0; tbv[4] = 64'h12345678_9ABCDEF0; ts[4] = 0; tc[4] = 3'b010;
        ta[5] = 64'h12345678_9ABCDEF0; tbv[5] = 64'h12345678_9ABCDEF0; ts[5] = 1; tc[5] = 3'b001;
        ta[6] = 64'hFFFFFFFF_FFFFFFFF; tbv[6] = 64'h0;                 ts[6] = 1; tc[6] = 3'b010;
        ta[7] = 64'h00010000_00000000; tbv[7] = 64'h00000000_00000000; ts[7] = 0; tc[7] = 3'b011;
        for (int t = 0; t < 8; t++) begin
            run_txn(ta[t], tbv[t], ts[t], tc[t]);
            exp_r = model_res(ta[t], tbv[t], ts[t], tc[t]);
            total++;
            if (obs_inready !== 4'hF) begin
                bad++;
                $display("FAIL dir%0d_in_ready got=%b required 1111", t, obs_inready);
            end
            for (int i = 0; i < 4; i++) begin
                exp_k = model_k(ta[t], tbv[t], ch_of(i), ee_of(i));
                total++;
                if (obs_res[i] !== exp_r) begin
                    bad++;
                    $display("FAIL dir%0d_result inst%0d got=%b required %b", t, i, obs_res[i], exp_r);
                end
                total++;
                if (obs_lat[i] != exp_k) begin
                    bad++;
                    $display("FAIL dir%0d_latency inst%0d got=%0d required %0d", t, i, obs_lat[i], exp_k);
                end
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_r;
        run_txn(64'h00000000_00000005, 64'h00000000_00000009, 1'b0, 3'b010);
        exp_r = 3'b001;
        for (int c = 0; c < 5; c++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            in_valid = c[0];
            @(posedge clk); #1;
            total++;
            if (out_valid !== 4'hF || in_ready !== 4'h0) begin
                bad++;
                $display("FAIL bp_hold cyc%0d out_valid=%b in_ready=%b required 1111/0000", c, out_valid, in_ready);
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if ({great[i], equal[i], less[i]} !== exp_r) begin
                    bad++;
                    $display("FAIL bp_stable cyc%0d inst%0d got=%b required %b", c, i, {great[i], equal[i], less[i]}, exp_r);
                end
            end
        end
        in_valid = 1'b0;
        release_out();
        total++;
        if (out_valid !== 4'h0 || in_ready !== 4'hF) begin
            bad++;
            $display("FAIL bp_release out_valid=%b in_ready=%b required 0000/1111", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        a = 64'hA5A5A5A5_A5A5A5A5; b = 64'hA5A5A5A5_A5A5A5A5; is_signed = 1'b0; casc = 3'b010;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'h0) begin
            bad++;
            $display("FAIL midrst_in_ready_low got=%b required 0000", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 4'hF) begin
            bad++;
            $display("FAIL midrst_in_ready_high got=%b required 1111", in_ready);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 4'h0) begin
                bad++;
                $display("FAIL midrst_no_valid cyc%0d got=%b required 0000", c, out_valid);
            end
        end
        run_txn(64'd3, 64'd5, 1'b0, 3'b010);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_res[i] !== 3'b001) begin
                bad++;
                $display("FAIL midrst_next inst%0d got=%b required 001", i, obs_res[i]);
            end
        end
        release_out();
    endtask

    // Grid over small values plus random wide pairs, both signedness modes.
    task automatic test_sweep();
        logic [63:0] x, y;
        logic        s;
        logic [2:0]  c;
        logic [2:0]  exp_r;
        int          exp_k;
        for (int n = 0; n < 1100; n++) begin
            if (n < 512) begin
                x = 64'((n % 16) * 17);
                y = 64'(((n / 16) % 16) * 17);
                s = n[9];
            end else begin
                x = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       y = x;
                    1:       y = x ^ (64'h1 << $urandom_range(0, 63));
                    default: y = {$urandom, $urandom};
                endcase
                s = $urandom_range(0, 1) == 1;
            end
            c = 3'($urandom_range(0, 7));
            run_txn(x, y, s, c);
            exp_r = model_res(x, y, s, c);
            for (int i = 0; i < 4; i++) begin
                exp_k = model_k(x, y, ch_of(i), ee_of(i));
                total++;
                if (obs_res[i] !== exp_r || obs_lat[i] != exp_k) begin
                    bad++;
                    $display("FAIL sweep%0d inst%0d res=%b lat=%0d required res=%b lat=%0d",
                             n, i, obs_res[i], obs_lat[i], exp_r, exp_k);
                end
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
